// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC, drives a single-outstanding req/ack instruction port,
// buffers one instruction for decode and absorbs execute-stage redirects
// without ever delivering a wrong-path instruction.
module fetch_ctrl #(
   parameter int              XLEN  = 32,
   parameter logic [XLEN-1:0] RESET = '0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            inst_valid,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_rvc
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [XLEN-1:0] fpc_reg, fpc_next;
   logic [XLEN-1:0] stale_addr_reg, stale_addr_next;
   logic            pending_reg, pending_next;
   logic            inst_valid_next;
   logic [31:0]     inst_next;
   logic [XLEN-1:0] inst_pc_next;
   logic            consume;
   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] fetch_step;

   // Targets are halfword aligned; bit 0 of the redirect address is ignored.
   assign redirect_target = {redirect_pc[XLEN-1:1], 1'b0};
   assign consume         = inst_valid && !stall;
   assign fetch_step      = (imem_rdata[1:0] == 2'b11) ? XLEN'(4) : XLEN'(2);

   // Only a buffered instruction can be compressed; an empty buffer (which
   // holds zero after reset) reports a non-compressed instruction.
   assign inst_rvc = inst_valid && (inst[1:0] != 2'b11);

   // Next-state, request and buffer-update logic.
   always_comb begin
      state_next      = state_reg;
      fpc_next        = fpc_reg;
      stale_addr_next = stale_addr_reg;
      pending_next    = 1'b0;
      inst_valid_next = inst_valid;
      inst_next       = inst;
      inst_pc_next    = inst_pc;
      imem_req        = 1'b0;
      imem_addr       = fpc_reg;

      case (state_reg)
         BOOT: begin
            // Redirects are ignored here; fetch always starts at RESET.
            state_next = FETCH;
         end

         FETCH: begin
            // A raised request is held until acked, whatever stall does.
            imem_req = pending_reg || !inst_valid || !stall;
            if (redirect) begin
               fpc_next        = redirect_target;
               inst_valid_next = 1'b0;
               // An unacked request must still be drained; its data is stale.
               if (imem_req && !imem_ack) begin
                  state_next      = DROP;
                  stale_addr_next = fpc_reg;
               end
            end else begin
               if (consume) begin
                  inst_valid_next = 1'b0;
               end
               if (imem_req && imem_ack) begin
                  inst_valid_next = 1'b1;
                  inst_next       = imem_rdata;
                  inst_pc_next    = fpc_reg;
                  fpc_next        = fpc_reg + fetch_step;
               end
               pending_next = imem_req && !imem_ack;
            end
         end

         DROP: begin
            // Keep the stale request alive until memory answers, then discard.
            imem_req        = 1'b1;
            imem_addr       = stale_addr_reg;
            inst_valid_next = 1'b0;
            if (redirect) begin
               fpc_next = redirect_target;
            end
            if (imem_ack) begin
               state_next = FETCH;
            end
         end

         default: begin
            state_next = BOOT;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg      <= BOOT;
         fpc_reg        <= {RESET[XLEN-1:1], 1'b0};
         stale_addr_reg <= '0;
         pending_reg    <= 1'b0;
         inst_valid     <= 1'b0;
         inst           <= '0;
         inst_pc        <= '0;
      end else begin
         state_reg      <= state_next;
         fpc_reg        <= fpc_next;
         stale_addr_reg <= stale_addr_next;
         pending_reg    <= pending_next;
         inst_valid     <= inst_valid_next;
         inst           <= inst_next;
         inst_pc        <= inst_pc_next;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl.
// The driver models instruction memory and, from the program-order rule
// (next pc = pc + 2 or 4 by the low two bits, restart on redirect/reset),
// queues the instructions decode must see. A separate monitor pops and
// compares on every delivery and checks the request/buffer hold rules.
module tb_fetch_ctrl;

   localparam int          XLEN   = 32;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_rvc;

   fetch_ctrl #(.XLEN(XLEN), .RESET(RST_PC)) dut (
      .clock      (clock),
      .reset      (reset),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_rvc   (inst_rvc)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] next_pc = RST_PC;

   // flags written by the driver, read by the monitor
   bit expect_idle  = 1'b0;
   bit expect_first = 1'b0;
   bit done         = 1'b0;

   // memory model state (driver only)
   int lat  = 0;
   bit busy = 1'b0;
   bit long_lat = 1'b0;

   // ---------------- reference memory contents ----------------
   function automatic logic [15:0] mem_half(input logic [31:0] a);
      logic [31:0] h;
      h = a * 32'h9E37_79B1;
      h = h ^ (h >> 15);
      h = h * 32'h85EB_CA6B;
      h = h ^ (h >> 13);
      return h[31:16] ^ h[15:0];
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem_half(a + 32'd2), mem_half(a)};
   endfunction

   // ---------------- program-order reference model ----------------
   task automatic refill();
      exp_t e;
      while (exp_q.size() < 8) begin
         e.pc   = next_pc;
         e.word = mem_word(next_pc);
         exp_q.push_back(e);
         next_pc = next_pc + ((e.word[1:0] == 2'b11) ? 32'd4 : 32'd2);
      end
   endtask

   task automatic restart(input logic [31:0] target);
      exp_q.delete();
      next_pc = {target[31:1], 1'b0};
      refill();
   endtask

   // memory responder: decides ack once imem_req has settled for this cycle
   task automatic mem_step();
      int r;
      #1;
      if (imem_req) begin
         if (!busy) begin
            busy = 1'b1;
            r    = $urandom_range(0, 9);
            lat  = long_lat ? 5 : ((r < 5) ? 0 : r - 5);
         end
         if (lat == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            busy       = 1'b0;
         end else begin
            lat        = lat - 1;
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
         end
      end else begin
         // ack outside a request carries no meaning and must be ignored
         busy       = 1'b0;
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
      end
   endtask

   // one clock cycle of stimulus; scoreboard updated in step with it
   task automatic cycle(input bit rst_n, input bit st, input bit rd,
                        input logic [31:0] tgt, input bit ei, input bit ef);
      @(posedge clock);
      #1;
      reset        = rst_n;
      stall        = st;
      redirect     = rd;
      redirect_pc  = tgt;
      expect_idle  = ei;
      expect_first = ef;
      if (!rst_n) restart(RST_PC);
      else if (rd) restart(tgt);
      refill();
      mem_step();
   endtask

   // ---------------- driver ----------------
   initial begin
      bit          st_cur;
      bit          prev_rst;
      bit          rd;
      logic [31:0] tgt;
      restart(RST_PC);
      // reset held two cycles, then the BOOT cycle
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      // first request at RESET
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

      st_cur   = 1'b0;
      prev_rst = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) < 3) st_cur = ~st_cur;
         rd  = 1'b0;
         tgt = $urandom;
         if (prev_rst && $urandom_range(0, 19) == 0) begin
            rd = 1'b1;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else tgt = 32'h100 + 32'($urandom_range(0, 4095));
         end
         if (prev_rst && i > 10 && $urandom_range(0, 399) == 0) begin
            cycle(1'b0, st_cur, 1'b0, tgt, 1'b0, 1'b0);
            prev_rst = 1'b0;
         end else begin
            // no redirect in the BOOT cycle right after reset release
            cycle(1'b1, st_cur, rd & prev_rst, tgt, 1'b0, 1'b0);
            prev_rst = 1'b1;
         end
      end

      // directed: redirect with a slow outstanding request, then reset in DROP
      long_lat = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
         if (imem_req && busy) break;
      end
      cycle(1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      long_lat = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++) begin
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0, 1'b0);
      end
      @(posedge clock);
      #1;
      done = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   int total = 0;
   int bad   = 0;
   int delivered = 0;

   task automatic chk(input string name, input bit ok,
                      input logic [63:0] act, input logic [63:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   logic        p_rst = 1'b0, p_req = 1'b0, p_ack = 1'b0;
   logic        p_valid = 1'b0, p_stall = 1'b0, p_redirect = 1'b0;
   logic [31:0] p_addr = '0, p_inst = '0, p_pc = '0;

   // Compare on every observed delivery and enforce the hold rules.
   always @(negedge clock) begin
      exp_t e;
      if (expect_idle) begin
         chk("idle", {imem_req, inst_valid, inst_rvc, inst, inst_pc} == 67'd0,
             {imem_req, inst_valid, inst_rvc, inst[28:0], inst_pc}, 64'd0);
      end
      if (expect_first) begin
         chk("first_req", imem_req == 1'b1 && imem_addr == RST_PC,
             {31'd0, imem_req, imem_addr}, {32'd1, RST_PC});
      end
      if (p_rst && p_req && !p_ack) begin
         chk("req_hold", imem_req == 1'b1 && imem_addr == p_addr,
             {31'd0, imem_req, imem_addr}, {32'd1, p_addr});
      end
      if (p_rst && p_valid && p_stall && !p_redirect) begin
         chk("stall_hold", inst_valid && inst == p_inst && inst_pc == p_pc,
             {inst, inst_pc}, {p_inst, p_pc});
      end
      if (reset && inst_valid && stall && imem_req) begin
         chk("req_while_stalled", p_rst && p_req && !p_ack,
             {63'd0, imem_req}, 64'd0);
      end
      if (reset && inst_valid && !stall && !redirect) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_inst", 1'b0, {inst_pc, inst}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            delivered++;
            chk("inst", inst_pc == e.pc && inst == e.word && inst_rvc == (e.word[1:0] != 2'b11),
                {inst_pc, inst}, {e.pc, e.word});
         end
      end
      if (done) begin
         chk("progress", delivered >= 200, 64'(delivered), 64'd200);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
      p_rst      <= reset;
      p_req      <= imem_req;
      p_ack      <= imem_ack;
      p_addr     <= imem_addr;
      p_valid    <= inst_valid;
      p_stall    <= stall;
      p_redirect <= redirect;
      p_inst     <= inst;
      p_pc       <= inst_pc;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
